// File: rtl/alu_rsv_station.sv
// ALU reservation station: buffers uops until all sources are resolved, snoops the CDB,
// and issues the oldest ready entry to the ALU over a ready/valid handshake.

package alu_rsv_station_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned OP_W  = 4;

  typedef struct packed {
    logic             is_renamed;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } operand_t;

  typedef struct packed {
    logic             is_valid;
    logic [OP_W-1:0]  opcode;
    logic [TAG_W-1:0] dest_tag;
    operand_t         src_0_a;
    operand_t         src_0_b;
    operand_t         src_1_a;
    operand_t         src_1_b;
  } instruction_t;

  typedef struct packed {
    logic             is_valid;
    logic [TAG_W-1:0] dest_tag;
    logic [XLEN-1:0]  result;
  } writeback_packet_t;

  localparam int unsigned INSTR_W = $bits(instruction_t);
  localparam int unsigned WB_W    = $bits(writeback_packet_t);
endpackage

module alu_rsv_station
  import alu_rsv_station_pkg::*;
#(
  parameter int unsigned RS_DEPTH = 8,
  parameter int unsigned NUM_CDB  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  output logic                    rs_rdy,
  input  logic [INSTR_W-1:0]      disp_packet,
  output logic [INSTR_W-1:0]      alu_packet,
  input  logic                    alu_rdy,
  input  logic [NUM_CDB*WB_W-1:0] cdb_ports
);

  localparam int unsigned IDX_W = $clog2(RS_DEPTH);

  instruction_t        entry_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] valid_q;
  // older_q[i][j] = 1 means entry j is older than entry i
  logic [RS_DEPTH-1:0] older_q [RS_DEPTH];

  writeback_packet_t   cdb [NUM_CDB];
  instruction_t        disp;
  instruction_t        disp_res;
  instruction_t        issue_pkt;
  logic [RS_DEPTH-1:0] ready;
  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic                issue_fire;
  logic                disp_fire;

  assign disp = disp_packet;

  // Unpack the flattened CDB bus
  always_comb begin
    for (int k = 0; k < int'(NUM_CDB); k++) begin
      cdb[k] = cdb_ports[k*WB_W +: WB_W];
    end
  end

  // Capture a CDB result for a waiting operand; lowest port wins on a duplicate tag
  function automatic operand_t resolve(input operand_t src);
    operand_t res;
    res = src;
    for (int k = int'(NUM_CDB) - 1; k >= 0; k--) begin
      if (src.is_renamed && cdb[k].is_valid && (cdb[k].dest_tag == src.tag)) begin
        res.is_renamed = 1'b0;
        res.data       = cdb[k].result;
      end
    end
    return res;
  endfunction

  // Dispatch bypass: resolve incoming sources against this cycle's broadcasts
  always_comb begin
    disp_res         = disp;
    disp_res.src_0_a = resolve(disp.src_0_a);
    disp_res.src_0_b = resolve(disp.src_0_b);
    disp_res.src_1_a = resolve(disp.src_1_a);
    disp_res.src_1_b = resolve(disp.src_1_b);
  end

  // Per-entry readiness from registered state only
  always_comb begin
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      ready[i] = valid_q[i] && !entry_q[i].src_0_a.is_renamed && !entry_q[i].src_0_b.is_renamed
                 && !entry_q[i].src_1_a.is_renamed && !entry_q[i].src_1_b.is_renamed;
    end
  end

  // Oldest-ready select: the ready entry with no older ready entry
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      if (ready[i] && ((older_q[i] & ready) == '0)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  // Lowest-index free slot
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign rs_rdy     = rst && free_found;
  assign issue_fire = rst && !flush && sel_found && alu_rdy;
  assign disp_fire  = rst && !flush && disp.is_valid && free_found;

  // Issue candidate; zeroed during reset, flush, or when nothing is ready
  always_comb begin
    issue_pkt = '0;
    if (rst && !flush && sel_found) begin
      issue_pkt          = entry_q[sel_idx];
      issue_pkt.is_valid = 1'b1;
    end
  end

  assign alu_packet = issue_pkt;

  // Entry state: wakeup, issue invalidation, allocation and age update
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(RS_DEPTH); i++) begin
        older_q[i] <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < int'(RS_DEPTH); i++) begin
        if (valid_q[i]) begin
          entry_q[i].src_0_a <= resolve(entry_q[i].src_0_a);
          entry_q[i].src_0_b <= resolve(entry_q[i].src_0_b);
          entry_q[i].src_1_a <= resolve(entry_q[i].src_1_a);
          entry_q[i].src_1_b <= resolve(entry_q[i].src_1_b);
        end
      end
      if (issue_fire) begin
        valid_q[sel_idx] <= 1'b0;
      end
      if (disp_fire) begin
        valid_q[free_idx] <= 1'b1;
        entry_q[free_idx] <= disp_res;
        older_q[free_idx] <= valid_q & ~(RS_DEPTH'(1) << free_idx);
        for (int j = 0; j < int'(RS_DEPTH); j++) begin
          older_q[j][free_idx] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_rsv_station.sv
// Self-checking bench for alu_rsv_station: directed vector table, ordering/full/flush/reset
// sequences, and randomized traffic checked every cycle against an age-ordered queue model.

module tb_alu_rsv_station;
  import alu_rsv_station_pkg::*;

  localparam int DEPTH = 8;
  localparam int NCDB  = 2;

  logic                 clk;
  logic                 rst;
  logic                 flush;
  logic                 alu_rdy;
  logic                 rs_rdy;
  instruction_t         disp;
  instruction_t         alu_pkt;
  writeback_packet_t    cdb_v [NCDB];
  logic [NCDB*WB_W-1:0] cdb_flat;

  int n_checks;
  int n_errors;

  instruction_t      mq[$];
  logic [TAG_W-1:0]  issued[$];
  instruction_t      obs_pkt;
  logic              obs_rdy;

  alu_rsv_station #(.RS_DEPTH(DEPTH), .NUM_CDB(NCDB)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .rs_rdy      (rs_rdy),
    .disp_packet (disp),
    .alu_packet  (alu_pkt),
    .alu_rdy     (alu_rdy),
    .cdb_ports   (cdb_flat)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NCDB; k++) cdb_flat[k*WB_W +: WB_W] = cdb_v[k];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_pkt(input string name, input logic [INSTR_W-1:0] act,
                         input logic [INSTR_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: age-ordered list of buffered uops ----------------
  function automatic operand_t m_res(input operand_t s);
    if (!s.is_renamed) return s;
    for (int k = 0; k < NCDB; k++) begin
      if (cdb_v[k].is_valid && cdb_v[k].dest_tag == s.tag) begin
        s.is_renamed = 1'b0;
        s.data       = cdb_v[k].result;
        return s;
      end
    end
    return s;
  endfunction

  function automatic instruction_t m_wake(input instruction_t u);
    u.src_0_a = m_res(u.src_0_a);
    u.src_0_b = m_res(u.src_0_b);
    u.src_1_a = m_res(u.src_1_a);
    u.src_1_b = m_res(u.src_1_b);
    return u;
  endfunction

  function automatic logic m_ready(input instruction_t u);
    return !u.src_0_a.is_renamed && !u.src_0_b.is_renamed &&
           !u.src_1_a.is_renamed && !u.src_1_b.is_renamed;
  endfunction

  function automatic instruction_t m_expect();
    instruction_t r;
    r = '0;
    foreach (mq[i]) begin
      if (m_ready(mq[i])) begin
        r = mq[i];
        r.is_valid = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_update();
    int   iss;
    logic acc;
    iss = -1;
    acc = disp.is_valid && rst && !flush && (mq.size() < DEPTH);
    if (!rst || flush) begin
      mq.delete();
      return;
    end
    foreach (mq[i]) if (iss < 0 && m_ready(mq[i])) iss = i;
    if (iss >= 0 && alu_rdy) mq.delete(iss);
    foreach (mq[i]) mq[i] = m_wake(mq[i]);
    if (acc) mq.push_back(m_wake(disp));
  endtask

  // One clock cycle: check outputs at negedge, advance model at posedge, clear pulses
  task automatic step();
    instruction_t exp;
    @(negedge clk);
    obs_pkt = alu_pkt;
    obs_rdy = rs_rdy;
    chk("rs_rdy", 64'(obs_rdy), 64'(rst && (mq.size() < DEPTH)));
    if (flush && rst) begin
      chk("alu_valid_in_flush", 64'(obs_pkt.is_valid), 64'(0));
    end else begin
      exp = rst ? m_expect() : '0;
      chk_pkt("alu_packet", obs_pkt, exp);
    end
    if (obs_pkt.is_valid && alu_rdy && rst && !flush) issued.push_back(obs_pkt.dest_tag);
    @(posedge clk);
    model_update();
    #1;
    disp  = '0;
    flush = 1'b0;
    for (int k = 0; k < NCDB; k++) cdb_v[k] = '0;
  endtask

  function automatic instruction_t mk_uop(input logic [TAG_W-1:0] dt);
    instruction_t u;
    u              = '0;
    u.is_valid     = 1'b1;
    u.opcode       = OP_W'(dt);
    u.dest_tag     = dt;
    u.src_0_a.data = 32'hA000_0000 | 32'(dt);
    u.src_0_b.data = 32'hB000_0000 | 32'(dt);
    u.src_1_a.data = 32'hC000_0000 | 32'(dt);
    u.src_1_b.data = 32'hD000_0000 | 32'(dt);
    return u;
  endfunction

  function automatic operand_t rand_src();
    operand_t s;
    s.is_renamed = ($urandom_range(0, 3) == 0);
    s.tag        = TAG_W'($urandom_range(0, 7));
    s.data       = $urandom();
    return s;
  endfunction

  function automatic operand_t get_src(input instruction_t p, input int sel);
    case (sel)
      0:       return p.src_0_a;
      1:       return p.src_0_b;
      2:       return p.src_1_a;
      default: return p.src_1_b;
    endcase
  endfunction

  function automatic instruction_t set_wait(input instruction_t p, input int sel,
                                            input logic [TAG_W-1:0] t);
    case (sel)
      0: begin p.src_0_a.is_renamed = 1'b1; p.src_0_a.tag = t; end
      1: begin p.src_0_b.is_renamed = 1'b1; p.src_0_b.tag = t; end
      2: begin p.src_1_a.is_renamed = 1'b1; p.src_1_a.tag = t; end
      3: begin p.src_1_b.is_renamed = 1'b1; p.src_1_b.tag = t; end
      default: ;
    endcase
    return p;
  endfunction

  task automatic bcast(input int port, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] r);
    cdb_v[port].is_valid = 1'b1;
    cdb_v[port].dest_tag = t;
    cdb_v[port].result   = r;
  endtask

  // Directed single-uop vectors: which source waits, broadcast timing, required latency
  typedef struct {
    int               src_sel;
    logic [TAG_W-1:0] wait_tag;
    int               port;
    int               delay;
    logic [XLEN-1:0]  result;
    int               exp_lat;
  } vec_t;

  vec_t vecs [5];

  initial begin
    instruction_t u;
    operand_t     s;

    vecs[0] = '{src_sel: -1, wait_tag: 6'd0,  port: 0, delay: 0, result: 32'h0,        exp_lat: 1};
    vecs[1] = '{src_sel: 1,  wait_tag: 6'd5,  port: 1, delay: 3, result: 32'h1234,     exp_lat: 4};
    vecs[2] = '{src_sel: 0,  wait_tag: 6'd9,  port: 0, delay: 0, result: 32'hCAFE_0009, exp_lat: 1};
    vecs[3] = '{src_sel: 2,  wait_tag: 6'd17, port: 0, delay: 1, result: 32'h5555_AAAA, exp_lat: 2};
    vecs[4] = '{src_sel: 3,  wait_tag: 6'd63, port: 1, delay: 2, result: 32'hFFFF_0001, exp_lat: 3};

    clk = 1'b0;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    flush = 1'b0;
    alu_rdy = 1'b1;
    disp = '0;
    for (int k = 0; k < NCDB; k++) cdb_v[k] = '0;

    // Reset
    step();
    step();
    chk("rs_rdy_in_reset", 64'(obs_rdy), 64'(0));
    chk_pkt("alu_packet_in_reset", obs_pkt, '0);
    rst = 1'b1;
    step();
    chk("rs_rdy_after_reset", 64'(obs_rdy), 64'(1));

    // Vector table
    for (int v = 0; v < 5; v++) begin
      u = mk_uop(TAG_W'(32 + v));
      if (vecs[v].src_sel >= 0) u = set_wait(u, vecs[v].src_sel, vecs[v].wait_tag);
      disp = u;
      if (vecs[v].src_sel >= 0 && vecs[v].delay == 0)
        bcast(vecs[v].port, vecs[v].wait_tag, vecs[v].result);
      step();
      chk("vec_rs_rdy_disp", 64'(obs_rdy), 64'(1));
      for (int c = 1; c <= vecs[v].exp_lat + 1; c++) begin
        if (vecs[v].src_sel >= 0 && c == vecs[v].delay)
          bcast(vecs[v].port, vecs[v].wait_tag, vecs[v].result);
        step();
        chk($sformatf("vec%0d_valid_c%0d", v, c), 64'(obs_pkt.is_valid), 64'(c == vecs[v].exp_lat));
        if (c == vecs[v].exp_lat) begin
          chk("vec_dest_tag", 64'(obs_pkt.dest_tag), 64'(32 + v));
          chk("vec_rs_rdy", 64'(obs_rdy), 64'(1));
          if (vecs[v].src_sel >= 0) begin
            s = get_src(obs_pkt, vecs[v].src_sel);
            chk("vec_src_data", 64'(s.data), 64'(vecs[v].result));
            chk("vec_src_renamed", 64'(s.is_renamed), 64'(0));
          end else begin
            chk("vec_src_1_b_data", 64'(obs_pkt.src_1_b.data), 64'(32'hD000_0020));
          end
        end
      end
    end

    // Oldest first: A waits, B and C ready -> B, C, A
    issued.delete();
    disp = set_wait(mk_uop(6'd21), 3, 6'd3); step();
    disp = mk_uop(6'd22); step();
    disp = mk_uop(6'd23); step();
    bcast(0, 6'd3, 32'h3333); step();
    step();
    step();
    chk("order1_count", 64'(issued.size()), 64'(3));
    if (issued.size() == 3) begin
      chk("order1_first", 64'(issued[0]), 64'(22));
      chk("order1_second", 64'(issued[1]), 64'(23));
      chk("order1_third", 64'(issued[2]), 64'(21));
    end

    // Oldest first: A and B both ready under backpressure -> A then B
    issued.delete();
    alu_rdy = 1'b0;
    disp = set_wait(mk_uop(6'd24), 0, 6'd3); step();
    disp = mk_uop(6'd25); step();
    bcast(1, 6'd3, 32'h4444); step();
    step();
    chk("hold_selects_older", 64'(obs_pkt.dest_tag), 64'(24));
    alu_rdy = 1'b1;
    step(); step(); step();
    chk("order2_count", 64'(issued.size()), 64'(2));
    if (issued.size() == 2) begin
      chk("order2_first", 64'(issued[0]), 64'(24));
      chk("order2_second", 64'(issued[1]), 64'(25));
    end

    // Full and backpressure
    issued.delete();
    alu_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      disp = mk_uop(TAG_W'(10 + i));
      step();
    end
    disp = mk_uop(6'd18);
    step();
    chk("full_rs_rdy", 64'(obs_rdy), 64'(0));
    alu_rdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("drain_valid", 64'(obs_pkt.is_valid), 64'(1));
      chk("drain_order", 64'(obs_pkt.dest_tag), 64'(10 + i));
    end
    step();
    chk("drain_empty", 64'(obs_pkt.is_valid), 64'(0));
    chk("drain_count", 64'(issued.size()), 64'(DEPTH));

    // Flush with concurrent dispatch
    issued.delete();
    alu_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin disp = mk_uop(TAG_W'(40 + i)); step(); end
    alu_rdy = 1'b1;
    flush = 1'b1;
    disp = mk_uop(6'd44);
    step();
    chk("flush_no_issue", 64'(obs_pkt.is_valid), 64'(0));
    step();
    chk("post_flush_valid", 64'(obs_pkt.is_valid), 64'(0));
    chk("post_flush_rs_rdy", 64'(obs_rdy), 64'(1));
    chk("flush_issued_none", 64'(issued.size()), 64'(0));

    // Reset mid-operation with concurrent dispatch
    alu_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin disp = mk_uop(TAG_W'(48 + i)); step(); end
    alu_rdy = 1'b1;
    rst = 1'b0;
    disp = mk_uop(6'd52);
    step();
    chk("midrst_rs_rdy", 64'(obs_rdy), 64'(0));
    chk_pkt("midrst_packet", obs_pkt, '0);
    rst = 1'b1;
    step();
    chk("post_rst_valid", 64'(obs_pkt.is_valid), 64'(0));
    chk("post_rst_rs_rdy", 64'(obs_rdy), 64'(1));

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      alu_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        u          = mk_uop(TAG_W'($urandom_range(0, 63)));
        u.src_0_a  = rand_src();
        u.src_0_b  = rand_src();
        u.src_1_a  = rand_src();
        u.src_1_b  = rand_src();
        disp       = u;
      end
      for (int k = 0; k < NCDB; k++) begin
        if ($urandom_range(0, 1) == 1) bcast(k, TAG_W'($urandom_range(0, 7)), $urandom());
      end
      if ($urandom_range(0, 79) == 0) flush = 1'b1;
      rst = ($urandom_range(0, 199) != 0);
      step();
    end
    rst = 1'b1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
